pwm_capture: RTL and testbench

- Receive-side counterpart of the team's PWM generator. It measures an incoming PWM waveform with a fixed 2^W-cycle frame and recovers the 3-bit duty code.
- Each frame starts on a rising edge, and the high time in clock cycles equals the duty code. The block publishes a recovered duty code with a one-cycle valid strobe, and flags frames that are malformed or stuck.
- Used in loopback self-test and as the input stage for the companion servo/LED decode path.

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_sync.sv | 32 +++
 rtl/pwm_capture.sv | 152 +++++++++++++++
 tb/tb_pwm_capture.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// PWM frame definitions shared by the PWM generator and the capture path.
// Keeps the frame length and capture state encoding consistent.
package pwm_pkg;

    localparam int W_DEFAULT = 3;

    function automatic int period(input int w);
        return 1 << w;
    endfunction

    typedef enum logic [1:0] {
        ACQ,
        HIGH,
        LOW
    } state_t;

endpackage

// File: rtl/pwm_sync.sv
// Input synchronizer for the asynchronous PWM line.
// Produces the synchronized level plus single-cycle rise/fall strobes.
module pwm_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;

    // Shift the raw line through the synchronizer and keep one delayed copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            s_d    <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures fixed-length frames and recovers the duty code.
// Flags short or stuck-high frames; duty 0 is recovered from a long low run.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int W           = W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pwm_in,
    output logic [W-1:0] dc_out,
    output logic         dc_valid,
    output logic         err,
    output logic         locked
);

    localparam int         PERIOD = period(W);
    localparam logic [W:0] PER    = PERIOD[W:0];
    localparam logic [W:0] ONE    = {{W{1'b0}}, 1'b1};

    logic s;
    logic rise;
    logic fall;

    pwm_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .pwm_in(pwm_in),
        .s     (s),
        .rise  (rise),
        .fall  (fall)
    );

    state_t       state_q, state_n;
    logic [W:0]   hi_q, hi_n;
    logic [W:0]   per_q, per_n;
    logic [W:0]   low_q, low_n;
    logic [W-1:0] dc_q, dc_n;
    logic         valid_q, valid_n;
    logic         err_q, err_n;
    logic         locked_q, locked_n;

    logic [W:0]   hi_inc;
    logic [W:0]   per_inc;
    logic [W:0]   low_inc;

    assign hi_inc  = (hi_q == PER) ? PER : hi_q + ONE;
    assign per_inc = (per_q == PER) ? PER : per_q + ONE;
    assign low_inc = (low_q == PER) ? PER : low_q + ONE;

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ACQ;
            hi_q     <= '0;
            per_q    <= '0;
            low_q    <= '0;
            dc_q     <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            hi_q     <= hi_n;
            per_q    <= per_n;
            low_q    <= low_n;
            dc_q     <= dc_n;
            valid_q  <= valid_n;
            err_q    <= err_n;
            locked_q <= locked_n;
        end
    end

    // Frame tracking: align on a rise, time the high and total length.
    always_comb begin
        state_n  = state_q;
        hi_n     = hi_q;
        per_n    = per_q;
        low_n    = low_q;
        dc_n     = dc_q;
        valid_n  = 1'b0;
        err_n    = 1'b0;
        locked_n = locked_q;
        unique case (state_q)
            ACQ: begin
                if (rise) begin
                    state_n = HIGH;
                    hi_n    = ONE;
                    per_n   = ONE;
                    low_n   = '0;
                end else if (!s) begin
                    if (low_inc == PER) begin
                        valid_n  = 1'b1;
                        dc_n     = '0;
                        locked_n = 1'b1;
                        low_n    = '0;
                    end else begin
                        low_n = low_inc;
                    end
                end
            end
            HIGH: begin
                if (fall) begin
                    state_n = LOW;
                    per_n   = per_inc;
                end else if (s) begin
                    hi_n  = hi_inc;
                    per_n = per_inc;
                    if (hi_inc == PER) begin
                        err_n    = 1'b1;
                        locked_n = 1'b0;
                        state_n  = ACQ;
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    if (per_q == PER) begin
                        dc_n     = hi_q[W-1:0];
                        valid_n  = 1'b1;
                        locked_n = 1'b1;
                    end else begin
                        err_n    = 1'b1;
                        locked_n = 1'b0;
                    end
                    state_n = HIGH;
                    hi_n    = ONE;
                    per_n   = ONE;
                end else if (!s) begin
                    if (per_q == PER) begin
                        state_n = ACQ;
                        low_n   = per_q - hi_q;
                    end else begin
                        per_n = per_inc;
                    end
                end
            end
            default: begin
                state_n = ACQ;
            end
        endcase
    end

    assign dc_out   = dc_q;
    assign dc_valid = valid_q;
    assign err      = err_q;
    assign locked   = locked_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed frame scenarios plus random frames.
// Expected outputs come from a timestamp-based frame model.
module tb_pwm_capture;

    localparam int W  = 3;
    localparam int SS = 2;
    localparam int P  = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pwm_in = 1'b0;
    logic [W-1:0] dc_out;
    logic         dc_valid;
    logic         err;
    logic         locked;

    pwm_capture #(
        .W          (W),
        .SYNC_STAGES(SS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pwm_in  (pwm_in),
        .dc_out  (dc_out),
        .dc_valid(dc_valid),
        .err     (err),
        .locked  (locked)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int miss = 0;

    // reference model state
    int           n = 0;
    int           t_rise = 0;
    int           t_fall = 0;
    int           lowrun = 0;
    bit           aligned = 0;
    bit           in_high = 0;
    logic         pipe[0:SS];
    logic [W-1:0] m_dc = '0;
    logic         m_valid = 1'b0;
    logic         m_err = 1'b0;
    logic         m_locked = 1'b0;

    logic pat[$];

    task automatic push(input int h, input int l);
        repeat (h) pat.push_back(1'b1);
        repeat (l) pat.push_back(1'b0);
    endtask

    // drive one cycle and advance the model by the same clock edge
    task automatic tick(input logic p, input logic r);
        logic sv, sd, rs, fl;
        pwm_in = p;
        rst    = r;
        @(posedge clk);
        n++;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (r) begin
            aligned  = 0;
            in_high  = 0;
            lowrun   = 0;
            m_dc     = '0;
            m_locked = 1'b0;
            for (int i = 0; i <= SS; i++) pipe[i] = 1'b0;
        end else begin
            sv = pipe[SS-1];
            sd = pipe[SS];
            rs = sv & ~sd;
            fl = ~sv & sd;
            if (!aligned) begin
                if (rs) begin
                    aligned = 1;
                    in_high = 1;
                    t_rise  = n;
                    lowrun  = 0;
                end else if (!sv) begin
                    lowrun++;
                    if (lowrun == P) begin
                        m_valid  = 1'b1;
                        m_dc     = '0;
                        m_locked = 1'b1;
                        lowrun   = 0;
                    end
                end
            end else if (in_high) begin
                if (fl) begin
                    in_high = 0;
                    t_fall  = n;
                end else if (n - t_rise + 1 == P) begin
                    m_err    = 1'b1;
                    m_locked = 1'b0;
                    aligned  = 0;
                end
            end else begin
                if (rs) begin
                    if (n - t_rise == P) begin
                        m_valid  = 1'b1;
                        m_dc     = W'(t_fall - t_rise);
                        m_locked = 1'b1;
                    end else begin
                        m_err    = 1'b1;
                        m_locked = 1'b0;
                    end
                    in_high = 1;
                    t_rise  = n;
                end else if (n - t_rise == P) begin
                    aligned = 0;
                    lowrun  = P - (t_fall - t_rise);
                end
            end
            for (int i = SS; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = p;
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        vecs++;
        if ({dc_out, dc_valid, err, locked} !== 6'b0) begin
            miss++;
            $display("FAIL reset got %h exp 00",
                     {dc_out, dc_valid, err, locked});
        end
        vecs++;
        if ({dc_out, dc_valid, err, locked}
            !== {m_dc, m_valid, m_err, m_locked}) begin
            miss++;
            $display("FAIL reset_model got %h exp %h",
                     {dc_out, dc_valid, err, locked},
                     {m_dc, m_valid, m_err, m_locked});
        end
    endtask

    task automatic test_basic();
        int nv = 0, ne = 0, last = -1, bad = 0;
        tick(1'b0, 1'b1);
        pat.delete();
        repeat (7) push(3, 5);
        foreach (pat[i]) begin
            tick(pat[i], 1'b0);
            vecs++;
            if ({dc_out, dc_valid, err, locked}
                !== {m_dc, m_valid, m_err, m_locked}) begin
                miss++;
                $display("FAIL basic cyc %0d got %h exp %h", i,
                         {dc_out, dc_valid, err, locked},
                         {m_dc, m_valid, m_err, m_locked});
            end
            if (dc_valid) begin
                nv++;
                if (dc_out !== 3'd3) bad++;
                if (last >= 0 && i - last != P) bad++;
                last = i;
            end
            if (err) ne++;
        end
        vecs++;
        if (nv != 6) begin
            miss++;
            $display("FAIL basic_count got %0d exp 6", nv);
        end
        vecs++;
        if (ne != 0 || bad != 0) begin
            miss++;
            $display("FAIL basic_shape got err=%0d bad=%0d exp 0/0", ne, bad);
        end
        vecs++;
        if (locked !== 1'b1) begin
            miss++;
            $display("FAIL basic_locked got %b exp 1", locked);
        end
    endtask

    task automatic test_duty0();
        int nv = 0, bad = 0;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 24; i++) begin
            tick(1'b0, 1'b0);
            vecs++;
            if ({dc_out, dc_valid, err, locked}
                !== {m_dc, m_valid, m_err, m_locked}) begin
                miss++;
                $display("FAIL duty0 cyc %0d got %h exp %h", i,
                         {dc_out, dc_valid, err, locked},
                         {m_dc, m_valid, m_err, m_locked});
            end
            if (dc_valid) begin
                nv++;
                if (dc_out !== 3'd0) bad++;
            end
            if (i == 6) begin
                vecs++;
                if (locked !== 1'b0) begin
                    miss++;
                    $display("FAIL duty0_prelock got %b exp 0", locked);
                end
            end
        end
        vecs++;
        if (nv != 3 || bad != 0) begin
            miss++;
            $display("FAIL duty0_count got %0d/%0d exp 3/0", nv, bad);
        end
        vecs++;
        if (locked !== 1'b1) begin
            miss++;
            $display("FAIL duty0_locked got %b exp 1", locked);
        end
    endtask

    task automatic test_boundary();
        logic [W-1:0] got[$];
        int ne = 0, bad = 0;
        tick(1'b0, 1'b1);
        pat.delete();
        push(7, 1);
        repeat (3) begin
            push(1, 7);
            push(7, 1);
        end
        push(3, 0);
        foreach (pat[i]) begin
            tick(pat[i], 1'b0);
            vecs++;
            if ({dc_out, dc_valid, err, locked}
                !== {m_dc, m_valid, m_err, m_locked}) begin
                miss++;
                $display("FAIL bound cyc %0d got %h exp %h", i,
                         {dc_out, dc_valid, err, locked},
                         {m_dc, m_valid, m_err, m_locked});
            end
            if (dc_valid) got.push_back(dc_out);
            if (err) ne++;
        end
        foreach (got[k]) begin
            if (got[k] !== ((k % 2 == 0) ? 3'd7 : 3'd1)) bad++;
        end
        vecs++;
        if (got.size() != 7 || bad != 0 || ne != 0) begin
            miss++;
            $display("FAIL bound_seq got n=%0d bad=%0d err=%0d exp 7/0/0",
                     got.size(), bad, ne);
        end
    endtask

    task automatic test_short_frame();
        int nv = 0, ne = 0, bad = 0;
        logic [W-1:0] edc = '1;
        logic elk = 1'b1;
        tick(1'b0, 1'b1);
        pat.delete();
        push(3, 5);
        push(3, 5);
        push(2, 4);
        push(3, 5);
        push(3, 5);
        push(3, 0);
        foreach (pat[i]) begin
            tick(pat[i], 1'b0);
            vecs++;
            if ({dc_out, dc_valid, err, locked}
                !== {m_dc, m_valid, m_err, m_locked}) begin
                miss++;
                $display("FAIL short cyc %0d got %h exp %h", i,
                         {dc_out, dc_valid, err, locked},
                         {m_dc, m_valid, m_err, m_locked});
            end
            if (dc_valid) begin
                nv++;
                if (dc_out !== 3'd3) bad++;
            end
            if (err) begin
                ne++;
                edc = dc_out;
                elk = locked;
            end
        end
        vecs++;
        if (ne != 1 || nv != 4 || bad != 0) begin
            miss++;
            $display("FAIL short_count got err=%0d v=%0d bad=%0d exp 1/4/0",
                     ne, nv, bad);
        end
        vecs++;
        if (edc !== 3'd3 || elk !== 1'b0) begin
            miss++;
            $display("FAIL short_hold got dc=%0d lk=%b exp 3/0", edc, elk);
        end
        vecs++;
        if (locked !== 1'b1) begin
            miss++;
            $display("FAIL short_relock got %b exp 1", locked);
        end
    endtask

    task automatic test_stuck_high();
        int n5 = 0, ne = 0, ei = -1;
        logic [W-1:0] edc = '1;
        logic elk = 1'b1;
        tick(1'b0, 1'b1);
        pat.delete();
        push(3, 5);
        push(3, 5);
        push(10, 3);
        repeat (3) push(5, 3);
        push(3, 0);
        foreach (pat[i]) begin
            tick(pat[i], 1'b0);
            vecs++;
            if ({dc_out, dc_valid, err, locked}
                !== {m_dc, m_valid, m_err, m_locked}) begin
                miss++;
                $display("FAIL stuck cyc %0d got %h exp %h", i,
                         {dc_out, dc_valid, err, locked},
                         {m_dc, m_valid, m_err, m_locked});
            end
            if (dc_valid && dc_out === 3'd5) n5++;
            if (err) begin
                ne++;
                ei  = i;
                edc = dc_out;
                elk = locked;
            end
        end
        vecs++;
        if (ne != 1 || ei != 16 + SS + P - 1) begin
            miss++;
            $display("FAIL stuck_err got n=%0d at %0d exp 1 at %0d",
                     ne, ei, 16 + SS + P - 1);
        end
        vecs++;
        if (edc !== 3'd3 || elk !== 1'b0) begin
            miss++;
            $display("FAIL stuck_hold got dc=%0d lk=%b exp 3/0", edc, elk);
        end
        vecs++;
        if (n5 != 3 || locked !== 1'b1) begin
            miss++;
            $display("FAIL stuck_recover got v5=%0d lk=%b exp 3/1", n5, locked);
        end
    endtask

    task automatic test_mid_reset();
        int nv = 0, bad = 0;
        logic [W-1:0] first = '0;
        tick(1'b0, 1'b1);
        pat.delete();
        push(4, 4);
        push(4, 4);
        push(2, 0);
        foreach (pat[i]) begin
            tick(pat[i], 1'b0);
            vecs++;
            if ({dc_out, dc_valid, err, locked}
                !== {m_dc, m_valid, m_err, m_locked}) begin
                miss++;
                $display("FAIL mrst_pre cyc %0d got %h exp %h", i,
                         {dc_out, dc_valid, err, locked},
                         {m_dc, m_valid, m_err, m_locked});
            end
        end
        vecs++;
        if (locked !== 1'b1) begin
            miss++;
            $display("FAIL mrst_prelock got %b exp 1", locked);
        end
        tick(1'b1, 1'b1);
        vecs++;
        if ({dc_out, dc_valid, err, locked} !== 6'b0) begin
            miss++;
            $display("FAIL mrst_zero got %h exp 00",
                     {dc_out, dc_valid, err, locked});
        end
        pat.delete();
        push(1, 4);
        push(4, 4);
        push(4, 4);
        push(3, 0);
        foreach (pat[i]) begin
            tick(pat[i], 1'b0);
            vecs++;
            if ({dc_out, dc_valid, err, locked}
                !== {m_dc, m_valid, m_err, m_locked}) begin
                miss++;
                $display("FAIL mrst_post cyc %0d got %h exp %h", i,
                         {dc_out, dc_valid, err, locked},
                         {m_dc, m_valid, m_err, m_locked});
            end
            if (dc_valid) begin
                if (nv == 0) first = dc_out;
                nv++;
                if (dc_out !== 3'd4) bad++;
            end
        end
        vecs++;
        if (nv != 2 || bad != 0 || first !== 3'd4) begin
            miss++;
            $display("FAIL mrst_report got v=%0d bad=%0d first=%0d exp 2/0/4",
                     nv, bad, first);
        end
    endtask

    task automatic test_random();
        int kind, h, l;
        tick(1'b0, 1'b1);
        pat.delete();
        repeat (40) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                h = $urandom_range(1, 7);
                l = P - h;
            end else if (kind == 6) begin
                h = $urandom_range(1, 3);
                l = $urandom_range(1, 3);
            end else if (kind == 7) begin
                h = $urandom_range(1, 6);
                l = P - h + $urandom_range(1, 6);
            end else if (kind == 8) begin
                h = 0;
                l = $urandom_range(8, 20);
            end else begin
                h = $urandom_range(8, 11);
                l = $urandom_range(1, 4);
            end
            push(h, l);
        end
        push(3, 0);
        foreach (pat[i]) begin
            tick(pat[i], 1'b0);
            vecs++;
            if ({dc_out, dc_valid, err, locked}
                !== {m_dc, m_valid, m_err, m_locked}) begin
                miss++;
                $display("FAIL random cyc %0d got %h exp %h", i,
                         {dc_out, dc_valid, err, locked},
                         {m_dc, m_valid, m_err, m_locked});
            end
        end
    endtask

    initial begin
        for (int i = 0; i <= SS; i++) pipe[i] = 1'b0;
        test_reset();
        test_basic();
        test_duty0();
        test_boundary();
        test_short_frame();
        test_stuck_high();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
